// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver (start + DATA_BITS + [even parity] + stop).
// Latency: 2 clk synchronizer, then result pulses one clk after the mid-stop-bit tick.
// Backpressure: none; rx_data is overwritten by every correctly framed word.
//
// Ports:
//   clk, rst       sole clock, synchronous active-high reset
//   s_tick         one-clk strobe, OVERSAMPLE per bit time
//   rx             asynchronous serial line, idle high
//   rx_data        last correctly framed word (LSB received first)
//   rx_valid       one-clk pulse, rx_data updated in that cycle
//   frame_err      one-clk pulse, stop bit sampled low
//   parity_err     one-clk pulse, even-parity mismatch (tied 0 unless parity is built)
//   rx_busy        high whenever the receiver is not idle
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic                 rx_prev;   // rx_s as seen on the previous tick, for edge detection
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
    // Even parity: data bits XOR parity bit must be zero.
    assign par_bad    = (^shreg) ^ par_bit;
    assign parity_err = par_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            // Cleared so a line that is already low when reset drops is not mistaken
            // for a falling edge; it must be seen high on a tick first.
            rx_prev   <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // All timing state moves only on ticks.
            if (s_tick) begin
                rx_prev <= rx_s;
                case (state)
                    IDLE: begin
                        if (rx_prev && !rx_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        // Re-check the line in the middle of the start bit; a high
                        // level here means the edge was a glitch.
                        if (cnt == HALF) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == LAST) begin
                            cnt     <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            // A framing error masks any parity result.
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                                par_err_q <= 1'b1;
`endif
                            end else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with default parameters (8 data bits, x16 oversample).
// Latency: s_tick every 4 clk, so one bit time is 64 clk.
// Backpressure: none; a negedge monitor tallies every output pulse.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       rst;
    logic       s_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor tallies (written only by the monitor process).
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         perr_cnt  = 0;
    int         both_cnt  = 0;
    logic [7:0] vq[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tick     (s_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one clk high out of every four, changed on the falling edge.
    initial begin
        int tc;
        tc = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = (tc == 3);
            tc = (tc + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            vq.push_back(rx_data);
        end
        if (frame_err)              ferr_cnt++;
        if (parity_err)             perr_cnt++;
        if (rx_valid && frame_err)  both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(BIT_CLK);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, stop bit. No idle after.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input bit use_par, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par_b);
        send_bit(stop_b);
        rx = 1'b1;
    endtask

    initial begin
        int v0, f0, p0, q0;

        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(5);

        check("reset_rx_valid",   {31'd0, rx_valid},   32'd0);
        check("reset_frame_err",  {31'd0, frame_err},  32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_rx_busy",    {31'd0, rx_busy},    32'd0);
        check("reset_rx_data",    {24'd0, rx_data},    32'd0);

        rst = 1'b0;
        wait_clk(2 * BIT_CLK);

        // Good frame 0xA5.
        v0 = valid_cnt; f0 = ferr_cnt; q0 = vq.size();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_clk(BIT_CLK);
        check("a5_valid_pulses", valid_cnt - v0, 32'd1);
        check("a5_ferr_pulses",  ferr_cnt - f0,  32'd0);
        check("a5_pulse_data",   (vq.size() > q0) ? {24'd0, vq[q0]} : 32'hDEAD, 32'hA5);
        check("a5_rx_data_held", {24'd0, rx_data}, 32'hA5);
        check("a5_idle_after",   {31'd0, rx_busy}, 32'd0);

        // 0x3C with a low stop bit.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clk(2 * BIT_CLK);
        check("ferr_pulses",     ferr_cnt - f0,  32'd1);
        check("ferr_no_valid",   valid_cnt - v0, 32'd0);
        check("ferr_data_kept",  {24'd0, rx_data}, 32'hA5);

        // Low glitch of 4 ticks (16 clk) on the idle line.
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rx = 1'b0;
        wait_clk(16);
        rx = 1'b1;
        wait_clk(4);
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        wait_clk(40);
        check("glitch_busy_low",  {31'd0, rx_busy}, 32'd0);
        wait_clk(BIT_CLK);
        check("glitch_no_pulses", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0), 32'd0);

        // 0xFF abandoned by reset in the middle of data bit 3.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        wait_clk(BIT_CLK / 2);
        check("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        wait_clk(3);
        check("rst_busy_low",   {31'd0, rx_busy}, 32'd0);
        check("rst_data_clear", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        wait_clk(12 * BIT_CLK);
        check("rst_no_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);

        // 0x01 after the reset.
        v0 = valid_cnt; q0 = vq.size();
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        wait_clk(BIT_CLK);
        check("x01_valid_pulses", valid_cnt - v0, 32'd1);
        check("x01_rx_data",      {24'd0, rx_data}, 32'h01);

        // Back-to-back 0x00 then 0xFF, no idle between stop and next start.
        v0 = valid_cnt; f0 = ferr_cnt; q0 = vq.size();
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        wait_clk(BIT_CLK);
        check("b2b_valid_pulses", valid_cnt - v0, 32'd2);
        check("b2b_ferr_pulses",  ferr_cnt - f0,  32'd0);
        check("b2b_first",  (vq.size() > q0)     ? {24'd0, vq[q0]}     : 32'hDEAD, 32'h00);
        check("b2b_second", (vq.size() > q0 + 1) ? {24'd0, vq[q0 + 1]} : 32'hDEAD, 32'hFF);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the correct even-parity bit is 1.
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        check("par_bad_perr",      perr_cnt - p0,  32'd1);
        check("par_bad_no_valid",  valid_cnt - v0, 32'd0);
        check("par_bad_data_kept", {24'd0, rx_data}, 32'hFF);
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("par_ok_valid",   valid_cnt - v0, 32'd1);
        check("par_ok_no_perr", perr_cnt - p0,  32'd0);
        check("par_ok_data",    {24'd0, rx_data}, 32'h07);
`else
        check("no_parity_pulses", perr_cnt, 32'd0);
`endif

        check("valid_ferr_never_together", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
